// File: rtl/flopen_pipe_pkg.sv
// flopen_pipe_pkg: shared helpers for the flopen_pipe register chain.
// Shared defines: `WIDTH, `Enable, `Disable, `Enable_ (defaults supplied here if absent).
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef Enable_
`define Enable_ 1'b0
`endif

package flopen_pipe_pkg;

    // Valid bit a stage takes on when it loads; a flush forces an empty slot.
    function automatic logic stage_next_valid(input logic up_valid, input logic flush);
        return up_valid && !flush;
    endfunction

endpackage

// File: rtl/flopen_pipe_stage.sv
// flopen_pipe_stage: one enabled register slot with bubble-collapsing ready.
// Optional macro FLOPEN_PIPE_FLUSH_EN adds a synchronous flush input.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef Enable_
`define Enable_ 1'b0
`endif

module flopen_pipe_stage
    import flopen_pipe_pkg::*;
#(
    parameter int WIDTH = `WIDTH
) (
`ifdef FLOPEN_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             clk,
    input  logic             rst_,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    logic flush_i;
`ifdef FLOPEN_PIPE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = `Disable;
`endif

    // A slot can load when it is empty or its occupant moves on this edge.
    assign rdy = !v || dn_ready;

    // Slot register: load on ready, clear valid on flush, data only captured for real words.
    always_ff @(posedge clk or negedge rst_) begin
        if (rst_ == `Enable_) begin
            v <= `Disable;
            d <= '0;
        end else begin
            if (flush_i || rdy) begin
                v <= stage_next_valid(up_valid, flush_i);
            end
            if (rdy && stage_next_valid(up_valid, flush_i)) begin
                d <= up_data;
            end
        end
    end

endmodule

// File: rtl/flopen_pipe.sv
// flopen_pipe: DEPTH enabled register stages with valid/ready at both ends.
// Optional macro FLOPEN_PIPE_FLUSH_EN adds the flush port (discard all in-flight words).
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef Disable
`define Disable 1'b0
`endif

module flopen_pipe
    import flopen_pipe_pkg::*;
#(
    parameter int WIDTH = `WIDTH,
    parameter int DEPTH = 4
) (
`ifdef FLOPEN_PIPE_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic             flush_i;
    logic [DEPTH-1:0] v;

`ifdef FLOPEN_PIPE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = `Disable;
`endif

    // Per-stage nets live inside each generate block so the ready chain is a
    // plain net-to-net path rather than a vector feeding back on itself.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn_rdy;
        logic             stg_v;
        logic [WIDTH-1:0] stg_d;
        logic             stg_rdy;

        if (i == 0) begin : g_first
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_next
            assign up_v = g_stage[i-1].stg_v;
            assign up_d = g_stage[i-1].stg_d;
        end

        if (i == DEPTH - 1) begin : g_last
            assign dn_rdy = out_ready;
        end else begin : g_mid
            assign dn_rdy = g_stage[i+1].stg_rdy;
        end

        flopen_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
`ifdef FLOPEN_PIPE_FLUSH_EN
            .flush    (flush),
`endif
            .clk      (clk),
            .rst_     (rst_),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (dn_rdy),
            .v        (stg_v),
            .d        (stg_d),
            .rdy      (stg_rdy)
        );

        assign v[i] = stg_v;
    end

    // A flush cycle refuses new input; otherwise ready ripples back from out_ready.
    assign in_ready  = g_stage[0].stg_rdy && !flush_i;
    assign out_valid = v[DEPTH-1];
    assign out_data  = g_stage[DEPTH-1].stg_d;

    // Occupancy is the population count of the registered valid bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(v[i]);
        end
    end

endmodule

// File: tb/tb_flopen_pipe.sv
// tb_flopen_pipe: table vectors, hand sequences and a random run against a conveyor model.
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_flopen_pipe;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       flush = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    flopen_pipe #(.WIDTH(8), .DEPTH(DEPTH)) dut (
`ifdef FLOPEN_PIPE_FLUSH_EN
        .flush     (flush),
`endif
        .clk       (clk),
        .rst_      (rst_),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: words on a conveyor of DEPTH slots, oldest first.
    typedef struct {
        logic [7:0] data;
        int         pos;
    } word_t;
    word_t q[$];

    function automatic bit word_moves(int k, bit ordy);
        if (q[k].pos == DEPTH - 1) return ordy;
        if (k == 0) return 1'b1;
        if (q[k-1].pos == q[k].pos + 1) return word_moves(k - 1, ordy);
        return 1'b1;
    endfunction

    function automatic bit model_in_ready(bit ordy);
        if (q.size() == 0) return 1'b1;
        if (q[q.size()-1].pos != 0) return 1'b1;
        return word_moves(q.size() - 1, ordy);
    endfunction

    task automatic model_step(input bit iv, input logic [7:0] id, input bit ordy);
        bit mv[$];
        bit acc;
        word_t w;
        acc = iv && model_in_ready(ordy);
        for (int k = 0; k < q.size(); k++) mv.push_back(word_moves(k, ordy));
        for (int k = 0; k < q.size(); k++) if (mv[k]) q[k].pos++;
        if (q.size() > 0 && q[0].pos == DEPTH) void'(q.pop_front());
        if (acc) begin
            w.data = id;
            w.pos  = 0;
            q.push_back(w);
        end
    endtask

    typedef struct {
        bit         iv;
        logic [7:0] id;
        bit         ordy;
        bit         ir;
        bit         ov;
        logic [7:0] od;
        int         cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        q.delete();
    endtask

    initial begin
        // latency
        tbl.push_back('{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 0});
        // fill while stalled
        tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h11, 1});
        tbl.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h11, 2});
        tbl.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'h11, 3});
        tbl.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 4});
        tbl.push_back('{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 4});
        tbl.push_back('{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 4});
        // full with simultaneous accept and emit
        tbl.push_back('{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02, 4});
        tbl.push_back('{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h03, 4});
        tbl.push_back('{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h04, 4});
        tbl.push_back('{1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 8'h05, 4});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06, 3});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h07, 2});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h08, 1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h08, 0});
        // bubble collapse
        tbl.push_back('{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h08, 1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h08, 1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h08, 1});
        tbl.push_back('{1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 8'hA0, 2});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA0, 2});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA0, 2});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA0, 2});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB0, 1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hB0, 0});

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_ = 1'b1;

        // table vectors
        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            in_valid  = tbl[r].iv;
            in_data   = tbl[r].id;
            out_ready = tbl[r].ordy;
            #1;
            chk($sformatf("row%0d in_ready", r), 32'(in_ready), 32'(tbl[r].ir));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(tbl[r].ov));
            chk($sformatf("row%0d out_data", r), 32'(out_data), 32'(tbl[r].od));
            chk($sformatf("row%0d count", r), 32'(count), 32'(tbl[r].cnt));
        end

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = 8'h40 + 8'(i);
            out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_ = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        chk("async rst out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        q.delete();

`ifdef FLOPEN_PIPE_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = 8'h60 + 8'(i);
            out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre-flush count", 32'(count), 32'd3);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("flush count", 32'(count), 32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) @(negedge clk);
        chk("flush 0x77 discarded", 32'(count), 32'd0);
        do_reset();
`endif

        // random traffic against the conveyor model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bit         iv;
            bit         ordy;
            logic [7:0] id;
            @(negedge clk);
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 55);
            id   = 8'($urandom);
            in_valid  = iv;
            in_data   = id;
            out_ready = ordy;
            #1;
            chk($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(model_in_ready(ordy)));
            chk($sformatf("rnd%0d count", c), 32'(count), 32'(q.size()));
            chk($sformatf("rnd%0d out_valid", c), 32'(out_valid),
                32'(q.size() > 0 && q[0].pos == DEPTH - 1));
            if (q.size() > 0 && q[0].pos == DEPTH - 1)
                chk($sformatf("rnd%0d out_data", c), 32'(out_data), 32'(q[0].data));
            @(posedge clk);
            model_step(iv, id, ordy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flopen_pipe.md
# flopen_pipe

Parametrised, multi-stage successor to the single enabled flop: a chain of DEPTH enabled register stages with a valid/ready handshake at each end. It collapses bubbles and accepts backpressure. It sits between datapath blocks that need registered, stallable transport of WIDTH-bit words without losing or duplicating data. An optional synchronous flush discards all in-flight words.

## Interface
- WIDTH, default `WIDTH: data width in bits.
- DEPTH, default 4: number of register stages. Legal range is DEPTH ≥ 1.
- clk  in  1  clock. All state updates on the rising edge.
- rst_  in  1  asynchronous, active-low reset (`Enable_ = 0 asserts).
- in_valid  in  1  upstream word present (`Enable = 1).
- in_ready  out  1  pipe can accept this cycle.
- in_data  in  WIDTH  upstream word.
- out_valid  out  1  stage DEPTH-1 holds a word.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  word held in stage DEPTH-1.
- count  out  $clog2(DEPTH+1)  number of valid stages.
- flush  in  1  discard all words. Present only with FLOPEN_PIPE_FLUSH_EN.

## Operation
- Per stage i (0 = input side, DEPTH-1 = output side): state is v[i] and d[i].
- rdy[DEPTH] = out_ready.
- rdy[i] = !v[i] || rdy[i+1] (bubble collapse).
- in_ready = rdy[0].
- Transfer into stage 0 when in_valid && rdy[0].
- Transfer from stage i-1 into stage i when v[i-1] && rdy[i].
- Stage i loads when rdy[i] is high:
  - v[i] <= upstream valid;
  - d[i] <= upstream data, only if upstream valid is set. Otherwise d[i] holds.
- Stage i holds (v and d unchanged) when rdy[i] is low (stall).
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- count = popcount(v), combinational from registered v.
- Handshake rules:
  - A word is transferred exactly when valid && ready on that edge.
  - Once out_valid is high, out_data is stable until the word is accepted.
  - Words are never dropped, duplicated or reordered.
- Boundaries:
  - Full (count = DEPTH) with out_ready low: in_ready = 0 and all stages hold.
  - Full with out_ready high: in_ready = 1. Simultaneous accept and emit leaves count = DEPTH.
  - Empty: out_valid = 0 and in_ready = 1.
  - Partially full with out_ready low: in_ready = 1 until the bubbles are consumed.

## Timing
- Reset: v[*] = 0 and d[*] = 0, so out_valid = 0, out_data = 0, count = 0 and in_ready = 1.
- Reset applies asynchronously. Mid-operation assertion clears all words immediately, without waiting for clk.
- Latency: a word accepted into an empty pipe appears on out_valid DEPTH cycles later (DEPTH rising edges).
- Throughput: 1 word/cycle sustained while out_ready is held high.
- in_ready is combinational from out_ready through the rdy chain. This is a documented ready path of depth DEPTH.
- The in_valid → out_valid path is fully registered.

## Configuration
- Macro: FLOPEN_PIPE_FLUSH_EN.
- Defined:
  - flush port exists.
  - flush high on an edge clears all v[*]; d[*] holds.
  - in_ready = 0 during a flush cycle, and in_valid is ignored that cycle.
  - flush has priority over all transfers. count = 0 in the next cycle.
- Undefined: the flush port is absent and the logic behaves as if flush = 0.

## Structure
- Shared defines (define.h): `WIDTH, `Enable, `Disable, `Enable_.
- No new package constants.
- One sub-module: flopen_pipe_stage.
  - Ports: clk, rst_, up_valid, up_data, dn_ready, flush (conditional), v, d, rdy.
  - flopen_pipe instantiates DEPTH stages with a generate loop.

## Test plan
- Reset/empty, WIDTH=8, DEPTH=4: assert rst_=0 mid-stream → out_valid=0, count=0, in_ready=1 immediately; out_data=0.
- Latency: out_ready=1, push 0x11 at cycle 0 → out_valid=1 with out_data=0x11 at cycle 4; count returns to 0 after accept.
- Full/stall, out_ready=0: push 0x01..0x04 → count=4, in_ready=0. A 5th push (0x05) is not accepted; out_data=0x01 stays stable.
- Simultaneous: from full, set out_ready=1 and push 0x05 each cycle → count stays 4. Output sequence 0x01,0x02,0x03,0x04,0x05 with no gaps.
- Bubble collapse: push 0xA0, idle two cycles, push 0xB0, with out_ready=0 → both packed into stages 3 and 2 (count=2). Release out_ready → 0xA0 then 0xB0 on consecutive cycles.
- Flush (FLOPEN_PIPE_FLUSH_EN defined): with count=3, flush=1 and in_valid=1 with 0x77 → next cycle count=0, out_valid=0, 0x77 discarded.
